// File: rtl/tjmono2_rx_merge.sv
// ---------------------------------------------------------------------------
// tjmono2_rx_merge
//
// Purpose:
//   N-lane merge stage for the TJ-Monopix2 RX readout path. Each receiver lane
//   buffers decoded 24-bit words in its own FIFO. A round-robin arbiter drains
//   the lanes into a single 32-bit first-word-fall-through output register:
//     FIFO_DATA = {DATA_IDENTIFIER[3:0], lane index[3:0], payload[23:0]}
//   Per-lane full, sticky overflow and (optionally) lost-word counters are
//   provided.
//
// Optional feature macro:
//   TJMONO2_RX_MERGE_LOST_CNT_EN
//     defined   : per-lane 8-bit saturating LOST_COUNT registers
//     undefined : no counter registers, LOST_COUNT tied to 0
//
// Ports:
//   BUS_CLK          in   clock for the whole block
//   BUS_RST_N        in   synchronous active-low reset
//   CH_WRITE         in   [NUM_CH]    per-lane write strobe
//   CH_DATA          in   [NUM_CH*24] lane k payload in [24k+23:24k]
//   CH_ENABLE        in   [NUM_CH]    per-lane enable
//   CLEAR_ERR        in   pulse, clears overflow flags and lost counters
//   CH_FULL          out  [NUM_CH]    lane FIFO holds DEPTH words
//   CH_OVERFLOW_ERR  out  [NUM_CH]    sticky, a write was dropped
//   LOST_COUNT       out  [NUM_CH*8]  dropped-word counters
//   FIFO_READ        in   consumer pop
//   FIFO_EMPTY       out  no valid output word
//   FIFO_DATA        out  [32]        output word
// ---------------------------------------------------------------------------
module tjmono2_rx_merge #(
  parameter int         NUM_CH          = 4,
  parameter int         DEPTH           = 16,
  parameter logic [3:0] DATA_IDENTIFIER = 4'd0
) (
  input  logic                 BUS_CLK,
  input  logic                 BUS_RST_N,
  input  logic [NUM_CH-1:0]    CH_WRITE,
  input  logic [NUM_CH*24-1:0] CH_DATA,
  input  logic [NUM_CH-1:0]    CH_ENABLE,
  input  logic                 CLEAR_ERR,
  output logic [NUM_CH-1:0]    CH_FULL,
  output logic [NUM_CH-1:0]    CH_OVERFLOW_ERR,
  output logic [NUM_CH*8-1:0]  LOST_COUNT,
  input  logic                 FIFO_READ,
  output logic                 FIFO_EMPTY,
  output logic [31:0]          FIFO_DATA
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [PW:0]   NCH   = (PW+1)'(NUM_CH);
  localparam logic [CW-1:0] FULLV = CW'(DEPTH);

  // Output register and arbiter pointer
  logic        r_empty;
  logic [31:0] r_data;
  logic [PW-1:0] r_ptr;

  // Per-lane status gathered from the lane generate blocks
  logic [NUM_CH-1:0] w_avail;
  logic [NUM_CH-1:0] w_pop;
  logic [23:0]       w_head [NUM_CH];

  // Rotated lane order starting at the pointer
  logic [PW:0]   w_rot_sum [NUM_CH];
  logic [PW-1:0] w_rot_idx [NUM_CH];

  logic          w_load;
  logic          w_grant_vld;
  logic [PW-1:0] w_grant;
  logic [3:0]    w_lane_tag;

  // The output register refills whenever it is empty or being consumed.
  assign w_load     = r_empty | FIFO_READ;
  assign w_lane_tag = 4'(w_grant);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_rot
    assign w_rot_sum[gi] = {1'b0, r_ptr} + (PW+1)'(gi);
    assign w_rot_idx[gi] = (w_rot_sum[gi] >= NCH) ? PW'(w_rot_sum[gi] - NCH)
                                                   : PW'(w_rot_sum[gi]);
  end

  // Walk from the farthest position back to the pointer so the first
  // available lane in round-robin order is the one that sticks.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant     = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_avail[w_rot_idx[i]]) begin
        w_grant_vld = 1'b1;
        w_grant     = w_rot_idx[i];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Lane FIFOs
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
    logic [23:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_cnt;
    logic          r_wr_last;
    logic          r_full;
    logic          r_ovf;

    logic          w_wr_req;
    logic          w_accept;
    logic          w_drop;
    logic [CW-1:0] w_cnt_next;

    assign w_wr_req   = CH_WRITE[gi] & CH_ENABLE[gi];
    // A full lane can still take a word when it is popped in the same cycle.
    assign w_accept   = w_wr_req & ((r_cnt != FULLV) | w_pop[gi]);
    assign w_drop     = w_wr_req & ~w_accept;
    assign w_pop[gi]  = w_load & w_grant_vld & (w_grant == PW'(gi));
    assign w_cnt_next = r_cnt + CW'(w_accept) - CW'(w_pop[gi]);

    // A word written on the previous edge is not yet eligible: this gives the
    // fixed two-edge write-to-output latency and keeps the memory write and
    // the output read of the same entry in different cycles.
    assign w_avail[gi] = (r_cnt > CW'(r_wr_last));
    assign w_head[gi]  = r_mem[r_rptr];

    always_ff @(posedge BUS_CLK) begin
      if (w_accept) begin
        r_mem[r_wptr] <= CH_DATA[24*gi +: 24];
      end
    end

    always_ff @(posedge BUS_CLK) begin
      if (!BUS_RST_N) begin
        r_wptr    <= '0;
        r_rptr    <= '0;
        r_cnt     <= '0;
        r_wr_last <= 1'b0;
        r_full    <= 1'b0;
        r_ovf     <= 1'b0;
      end else begin
        r_wr_last <= w_accept;
        r_cnt     <= w_cnt_next;
        r_full    <= (w_cnt_next == FULLV);
        if (w_accept) begin
          r_wptr <= r_wptr + 1'b1;
        end
        if (w_pop[gi]) begin
          r_rptr <= r_rptr + 1'b1;
        end
        // A drop in the same cycle as CLEAR_ERR leaves the flag set.
        if (w_drop) begin
          r_ovf <= 1'b1;
        end else if (CLEAR_ERR) begin
          r_ovf <= 1'b0;
        end
      end
    end

    assign CH_FULL[gi]         = r_full;
    assign CH_OVERFLOW_ERR[gi] = r_ovf;

`ifdef TJMONO2_RX_MERGE_LOST_CNT_EN
    logic [7:0] r_lost;

    always_ff @(posedge BUS_CLK) begin
      if (!BUS_RST_N) begin
        r_lost <= '0;
      end else if (w_drop) begin
        if (CLEAR_ERR) begin
          r_lost <= 8'd1;
        end else if (r_lost != 8'hFF) begin
          r_lost <= r_lost + 8'd1;
        end
      end else if (CLEAR_ERR) begin
        r_lost <= '0;
      end
    end

    assign LOST_COUNT[8*gi +: 8] = r_lost;
`else
    assign LOST_COUNT[8*gi +: 8] = 8'd0;
`endif
  end

  // -------------------------------------------------------------------------
  // Output register and arbiter pointer
  // -------------------------------------------------------------------------
  always_ff @(posedge BUS_CLK) begin
    if (!BUS_RST_N) begin
      r_empty <= 1'b1;
      r_data  <= '0;
      r_ptr   <= '0;
    end else if (w_load) begin
      if (w_grant_vld) begin
        r_empty <= 1'b0;
        r_data  <= {DATA_IDENTIFIER, w_lane_tag, w_head[w_grant]};
        r_ptr   <= (w_grant == PW'(NUM_CH - 1)) ? '0 : w_grant + 1'b1;
      end else begin
        // Nothing to load: data holds its last value.
        r_empty <= 1'b1;
      end
    end
  end

  assign FIFO_EMPTY = r_empty;
  assign FIFO_DATA  = r_data;

endmodule

// File: tb/tb_tjmono2_rx_merge.sv
module tb_tjmono2_rx_merge;

  localparam int         NUM_CH = 4;
  localparam int         DEPTH  = 16;
  localparam logic [3:0] ID     = 4'd5;

`ifdef TJMONO2_RX_MERGE_LOST_CNT_EN
  localparam bit LOST_EN = 1'b1;
`else
  localparam bit LOST_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic [NUM_CH-1:0]    wr;
  logic [NUM_CH*24-1:0] wdata;
  logic [NUM_CH-1:0]    en;
  logic                 clr;
  logic                 rd;
  logic [NUM_CH-1:0]    full;
  logic [NUM_CH-1:0]    ovf;
  logic [NUM_CH*8-1:0]  lost;
  logic                 empty;
  logic [31:0]          data;

  tjmono2_rx_merge #(
    .NUM_CH(NUM_CH), .DEPTH(DEPTH), .DATA_IDENTIFIER(ID)
  ) dut (
    .BUS_CLK(clk), .BUS_RST_N(rst_n), .CH_WRITE(wr), .CH_DATA(wdata),
    .CH_ENABLE(en), .CLEAR_ERR(clr), .CH_FULL(full), .CH_OVERFLOW_ERR(ovf),
    .LOST_COUNT(lost), .FIFO_READ(rd), .FIFO_EMPTY(empty), .FIFO_DATA(data)
  );

  // ---------------- reference model: queues of (payload, write edge) -------
  typedef struct {
    logic [23:0] d;
    int          t;
  } word_t;

  word_t            q [NUM_CH][$];
  int               cyc = 0;
  logic             m_empty = 1'b1;
  logic [31:0]      m_data = '0;
  int               m_ptr = 0;
  logic [NUM_CH-1:0] m_ovf = '0;
  int               m_lost [NUM_CH];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    int pop_lane;
    logic [NUM_CH-1:0] acc;
    logic [NUM_CH-1:0] drp;
    cyc++;
    if (!rst_n) begin
      for (int k = 0; k < NUM_CH; k++) begin
        q[k].delete();
        m_lost[k] = 0;
      end
      m_ovf = '0; m_empty = 1'b1; m_data = '0; m_ptr = 0;
      return;
    end
    pop_lane = -1;
    if (m_empty || rd) begin
      for (int i = 0; i < NUM_CH; i++) begin
        int k;
        k = (m_ptr + i) % NUM_CH;
        // eligible once at least one full cycle has passed since its write
        if (pop_lane < 0 && q[k].size() > 0 && q[k][0].t <= cyc - 2) pop_lane = k;
      end
    end
    acc = '0; drp = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (wr[k] && en[k]) begin
        if (q[k].size() < DEPTH || pop_lane == k) acc[k] = 1'b1;
        else drp[k] = 1'b1;
      end
    end
    if (rd && !m_empty)
      $display("read: lane %0d data %h (cycle %0d)", m_data[27:24], m_data, cyc);
    if (pop_lane >= 0) begin
      m_data  = {ID, 4'(pop_lane), q[pop_lane][0].d};
      m_empty = 1'b0;
      m_ptr   = (pop_lane + 1) % NUM_CH;
      void'(q[pop_lane].pop_front());
    end else if (m_empty || rd) begin
      m_empty = 1'b1;
    end
    for (int k = 0; k < NUM_CH; k++) begin
      if (acc[k]) begin
        word_t w;
        w.d = wdata[24*k +: 24];
        w.t = cyc;
        q[k].push_back(w);
      end
      if (drp[k]) begin
        m_ovf[k]  = 1'b1;
        m_lost[k] = clr ? 1 : ((m_lost[k] < 255) ? m_lost[k] + 1 : 255);
      end else if (clr) begin
        m_ovf[k]  = 1'b0;
        m_lost[k] = 0;
      end
    end
  endtask

  task automatic compare_model();
    chk("model_empty", 32'(empty), 32'(m_empty));
    chk("model_data", data, m_data);
    for (int k = 0; k < NUM_CH; k++) begin
      chk($sformatf("model_full[%0d]", k), 32'(full[k]), 32'(q[k].size() == DEPTH));
      chk($sformatf("model_ovf[%0d]", k), 32'(ovf[k]), 32'(m_ovf[k]));
      chk($sformatf("model_lost[%0d]", k), 32'(lost[8*k +: 8]), LOST_EN ? 32'(m_lost[k]) : 32'd0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  task automatic idle();
    wr = '0; rd = 1'b0; clr = 1'b0; en = '1; wdata = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [NUM_CH-1:0] wr;
    logic              rd;
    logic              exp_empty;
    logic [31:0]       exp_data;
  } vec_t;

  vec_t tbl [7];
  logic [31:0] exp_seq [8];

  initial begin
    for (int k = 0; k < NUM_CH; k++) m_lost[k] = 0;
    rst_n = 1'b0;
    idle();

    // Round-robin table: all lanes written once, consumer always reading
    tbl[0] = '{4'hF, 1'b1, 1'b1, 32'h0};
    tbl[1] = '{4'h0, 1'b1, 1'b1, 32'h0};
    tbl[2] = '{4'h0, 1'b1, 1'b0, 32'h50C0DE00};
    tbl[3] = '{4'h0, 1'b1, 1'b0, 32'h51C0DE01};
    tbl[4] = '{4'h0, 1'b1, 1'b0, 32'h52C0DE02};
    tbl[5] = '{4'h0, 1'b1, 1'b0, 32'h53C0DE03};
    tbl[6] = '{4'h0, 1'b1, 1'b1, 32'h53C0DE03};

    // ---- reset state
    do_reset();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_data", data, 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_lost", lost, 32'd0);

    // ---- single word latency
    $display("txn: lane 2 single write");
    wr = 4'b0100; wdata[2*24 +: 24] = 24'hABCDEF;
    step();
    idle();
    step();
    chk("lat_empty_t1", 32'(empty), 32'd1);
    step();
    chk("lat_empty_t2", 32'(empty), 32'd0);
    chk("lat_data", data, 32'h52ABCDEF);
    rd = 1'b1; step(); rd = 1'b0;
    chk("lat_drained", 32'(empty), 32'd1);

    // ---- round-robin table from pointer 0
    do_reset();
    $display("txn: four-lane round robin");
    for (int k = 0; k < NUM_CH; k++) wdata[24*k +: 24] = 24'hC0DE00 | 24'(k);
    for (int i = 0; i < 7; i++) begin
      wr = tbl[i].wr; rd = tbl[i].rd;
      step();
      chk($sformatf("rr%0d_empty", i), 32'(empty), 32'(tbl[i].exp_empty));
      chk($sformatf("rr%0d_data", i), data, tbl[i].exp_data);
    end
    idle();

    // ---- lanes 0 and 3 backlogged after lane 0 was granted last
    $display("txn: lane 0 grant, then 0/3 backlog");
    wr = 4'b0001; wdata[23:0] = 24'h0F0F0F;
    step(); idle(); step(); step();
    chk("bl_lane0_word", data, 32'h500F0F0F);
    rd = 1'b1; step();
    chk("bl_empty", 32'(empty), 32'd1);
    step(); rd = 1'b0;   // read while empty: ignored
    chk("bl_rd_empty_hold_e", 32'(empty), 32'd1);
    chk("bl_rd_empty_hold_d", data, 32'h500F0F0F);
    for (int i = 0; i < 4; i++) begin
      wr = 4'b1001;
      wdata[0 +: 24]  = 24'hA00000 + 24'(i);
      wdata[72 +: 24] = 24'hD00000 + 24'(i);
      step();
    end
    idle(); step();
    for (int j = 0; j < 8; j++)
      exp_seq[j] = (j % 2 == 0) ? {ID, 4'd3, 24'hD00000 + 24'(j/2)}
                                : {ID, 4'd0, 24'hA00000 + 24'(j/2)};
    chk("bl_seq0", data, exp_seq[0]);
    rd = 1'b1;
    for (int j = 1; j < 8; j++) begin
      step();
      chk($sformatf("bl_seq%0d", j), data, exp_seq[j]);
    end
    step(); rd = 1'b0;
    chk("bl_done_empty", 32'(empty), 32'd1);

    // ---- lane 1 overflow with the output register occupied
    $display("txn: lane 1 overflow");
    wr = 4'b0001; wdata[23:0] = 24'h000777;
    step(); idle(); step(); step();
    chk("of_hold_word", data, 32'h50000777);
    for (int i = 0; i < DEPTH + 3; i++) begin
      wr = 4'b0010; wdata[24 +: 24] = 24'hB10000 + 24'(i);
      step();
    end
    chk("of_full1", 32'(full[1]), 32'd1);
    chk("of_ovf1", 32'(ovf[1]), 32'd1);
    chk("of_lost1", 32'(lost[15:8]), LOST_EN ? 32'd3 : 32'd0);

    // ---- saturation and CLEAR_ERR
    for (int i = 0; i < 300; i++) step();
    chk("sat_lost1", 32'(lost[15:8]), LOST_EN ? 32'd255 : 32'd0);
    wr = '0; clr = 1'b1; step(); clr = 1'b0;
    chk("clr_ovf1", 32'(ovf[1]), 32'd0);
    chk("clr_lost1", 32'(lost[15:8]), 32'd0);
    wr = 4'b0010; clr = 1'b1; step(); idle();
    chk("clrdrop_ovf1", 32'(ovf[1]), 32'd1);
    chk("clrdrop_lost1", 32'(lost[15:8]), LOST_EN ? 32'd1 : 32'd0);

    // ---- first DEPTH lane 1 words come out intact and in order
    rd = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      step();
      chk($sformatf("of_read%0d", i), data, {ID, 4'd1, 24'hB10000 + 24'(i)});
    end
    step(); rd = 1'b0;
    chk("of_read_empty", 32'(empty), 32'd1);

    // ---- reset mid-stream with writes active
    $display("txn: reset with 5 buffered words");
    for (int i = 0; i < 5; i++) begin
      wr = 4'b0100; wdata[48 +: 24] = 24'hC20000 + 24'(i);
      step();
    end
    idle(); step(); step();
    chk("mr_pre_empty", 32'(empty), 32'd0);
    rst_n = 1'b0; wr = '1; wdata = {NUM_CH{24'h123456}};
    step();
    chk("mr_empty", 32'(empty), 32'd1);
    chk("mr_data", data, 32'd0);
    chk("mr_ovf", 32'(ovf), 32'd0);
    chk("mr_full", 32'(full), 32'd0);
    chk("mr_lost", lost, 32'd0);
    rst_n = 1'b1; idle();
    step(); step(); step();
    chk("mr_not_stored", 32'(empty), 32'd1);

    // ---- randomized traffic against the model
    $display("txn: random traffic");
    for (int ph = 0; ph < 9; ph++) begin
      int rd_pct;
      rd_pct = (ph % 3 == 0) ? 10 : ((ph % 3 == 1) ? 50 : 95);
      for (int c = 0; c < 220; c++) begin
        wr    = NUM_CH'($urandom);
        en    = NUM_CH'($urandom) | NUM_CH'($urandom);
        for (int k = 0; k < NUM_CH; k++) wdata[24*k +: 24] = 24'($urandom);
        rd    = ($urandom_range(0, 99) < rd_pct);
        clr   = ($urandom_range(0, 49) == 0);
        rst_n = ($urandom_range(0, 999) != 0);
        step();
      end
    end
    rst_n = 1'b1; idle();
    rd = 1'b1;
    for (int c = 0; c < NUM_CH * DEPTH + 8; c++) step();
    rd = 1'b0;
    chk("final_empty", 32'(empty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tjmono2_rx_merge.md
Name: tjmono2_rx_merge

Overview:
Parametrised N-channel successor to the single-lane TJ-Monopix2 RX readout path. Accepts decoded 24-bit data words from NUM_CH receiver lanes and buffers each lane in its own FIFO. A round-robin arbiter merges the lanes into one 32-bit first-word-fall-through stream for the readout FIFO arbiter, tagging each word with DATA_IDENTIFIER and lane index. Also provides per-lane enable, full, sticky overflow and lost-word accounting.

Parameters:
NUM_CH, 4, number of receiver lanes; legal range 1..16.
DEPTH, 16, per-lane FIFO depth in words; power of 2, minimum 2.
DATA_IDENTIFIER, 0, 4-bit tag placed in FIFO_DATA[31:28].

Ports:
BUS_CLK  in  1  single clock for the whole block.
BUS_RST_N  in  1  synchronous, active-low reset.
CH_WRITE  in  NUM_CH  per-lane write strobe, one word per asserted bit per cycle.
CH_DATA  in  NUM_CH*24  lane k payload in bits [24k+23:24k].
CH_ENABLE  in  NUM_CH  per-lane enable.
CLEAR_ERR  in  1  one-cycle pulse; clears overflow flags and lost counters.
CH_FULL  out  NUM_CH  lane FIFO holds DEPTH words.
CH_OVERFLOW_ERR  out  NUM_CH  sticky; set when a write to lane k is dropped.
LOST_COUNT  out  NUM_CH*8  per-lane dropped-word counter (only with the optional feature; otherwise tied 0).
FIFO_READ  in  1  consumer pop.
FIFO_EMPTY  out  1  high when no valid output word is available.
FIFO_DATA  out  32  {DATA_IDENTIFIER[3:0], lane index[3:0], payload[23:0]}.

Behaviour:
- Reset, with BUS_RST_N low at a rising edge:
  - all lane FIFOs empty; arbiter pointer = 0.
  - FIFO_EMPTY=1, FIFO_DATA=0, CH_FULL=0, CH_OVERFLOW_ERR=0, LOST_COUNT=0.
  - Reset wins over every other event in the same cycle. Reset mid-stream discards all buffered words.
- Lane write:
  - A word is accepted when CH_WRITE[k] & CH_ENABLE[k] and either count<DEPTH, or count==DEPTH with a pop from lane k in the same cycle.
  - Otherwise, when CH_ENABLE[k]=1, the word is dropped, CH_OVERFLOW_ERR[k] is set and LOST_COUNT[k] increments.
  - Writes with CH_ENABLE[k]=0 are ignored and not counted. Buffered words of a disabled lane still drain.
- Per-lane count width is log2(DEPTH)+1. Read and write pointers wrap modulo DEPTH. CH_FULL[k] is registered from count==DEPTH.
- Output register (first-word-fall-through):
  - Loads when FIFO_EMPTY=1, or when FIFO_EMPTY=0 and FIFO_READ=1 (back-to-back, one word per cycle sustained).
  - FIFO_READ while FIFO_EMPTY=1 is ignored.
  - If no lane has data at load time, FIFO_EMPTY goes 1 and FIFO_DATA holds its last value.
- Arbiter:
  - Searches lanes starting at pointer p, in order p, p+1, … mod NUM_CH. The first non-empty lane is granted and popped.
  - After a grant of lane g, p becomes (g+1) mod NUM_CH. With no grant, p is unchanged.
  - At most one pop per cycle.
- Latency: a word written at edge t into an idle, empty block gives FIFO_EMPTY=0 and valid FIFO_DATA after edge t+2.
- Ordering: words within one lane leave in write order. Across lanes the order is defined solely by round-robin.
- NUM_CH=1: lane index field is 0 and the arbiter degenerates to pass-through.
- CLEAR_ERR: clears flags and counters at the next edge. A drop in the same cycle as CLEAR_ERR wins: flag=1, count=1.

Optional Feature:
TJMONO2_RX_MERGE_LOST_CNT_EN
- Defined: per-lane 8-bit LOST_COUNT, saturating at 255 (no wrap), cleared by CLEAR_ERR or reset.
- Undefined: no counter registers; LOST_COUNT tied to 0. CH_OVERFLOW_ERR behaviour is unchanged.

Test Plan:
1. Reset, then write lane 2 payload 0xABCDEF at edge t with DATA_IDENTIFIER=5 -> FIFO_EMPTY=0 after edge t+2, FIFO_DATA=0x52ABCDEF.
2. All 4 lanes write one word in the same cycle, FIFO_READ held 1 -> output lane order 0,1,2,3 on consecutive cycles, then FIFO_EMPTY=1.
3. Lane 1 gets DEPTH+3 writes with FIFO_READ=0 -> CH_FULL[1]=1, CH_OVERFLOW_ERR[1]=1, LOST_COUNT[1]=3 (macro defined) or 0 (undefined). First DEPTH words are later read intact and in order.
4. Lane 1 gets 300 dropped writes -> LOST_COUNT[1]=255. A CLEAR_ERR pulse -> flag=0, count=0. CLEAR_ERR coincident with a drop -> flag=1, count=1.
5. Lanes 0 and 3 continuously backlogged, lane 0 granted last -> grants alternate 3,0,3,0. FIFO_READ pulsed while FIFO_EMPTY=1 -> no state change.
6. Hold BUS_RST_N low for one cycle with 5 words buffered and CH_WRITE active -> FIFO_EMPTY=1 and all flags 0 next cycle. The write in the reset cycle is not stored.
